prng_stream: RTL and testbench

Parametrised pseudo-random generator: successor to the fixed 32-bit LCG, with selectable LCG or Galois-LFSR stepping, seed reload, a valid/ready output stream and unbiased bounded output by rejection sampling. It feeds game and test logic that needs random values in [0, bound) under backpressure. It replaces direct free-running `o_rand` taps.

---
 rtl/prng_stream.sv | 131 +++++++++++++
 tb/tb_prng_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prng_stream.sv
//------------------------------------------------------------------------------
// Module   : prng_stream
// Brief    : LCG / Galois-LFSR pseudo-random stream with seed reload,
//            valid/ready output and unbiased bounded samples by rejection.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prng_stream #(
    parameter int          WIDTH        = 32,
    parameter int          SEED_W       = 16,
    parameter int          OUT_W        = 16,
    parameter logic [31:0] MULT         = 32'd1664525,
    parameter logic [31:0] INC          = 32'd1013904223,
    parameter logic [31:0] TAPS         = 32'h80200003,
    parameter logic [31:0] DEFAULT_SEED = 32'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed,
    input  logic              seed_load,
    input  logic              mode,
    input  logic [OUT_W-1:0]  bound,
    input  logic              ready,
    output logic [OUT_W-1:0]  o_rand,
    output logic              o_valid,
    output logic [7:0]        o_rej_cnt
);

    localparam logic [WIDTH-1:0] C_MULT = WIDTH'(MULT);
    localparam logic [WIDTH-1:0] C_INC  = WIDTH'(INC);
    localparam logic [WIDTH-1:0] C_TAPS = WIDTH'(TAPS);
    localparam logic [WIDTH-1:0] C_DSEED = WIDTH'(DEFAULT_SEED);

    typedef enum logic [0:0] {
        GEN   = 1'b0,
        VALID = 1'b1
    } fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [WIDTH-1:0]  prng_q, prng_d;
    logic              mode_q, mode_d;
    logic [OUT_W-1:0]  bound_q, bound_d;
    logic [OUT_W-1:0]  rand_q, rand_d;
    logic              valid_q, valid_d;
    logic [7:0]        rej_q, rej_d;

    logic [WIDTH-1:0]  w_lcg;
    logic [WIDTH-1:0]  w_lfsr;
    logic [WIDTH-1:0]  w_next;
    logic [WIDTH-1:0]  w_seed_ext;
    logic [OUT_W-1:0]  w_mask;
    logic [OUT_W-1:0]  w_cand;
    logic              w_accept;
    logic              w_step;

    always_comb begin
        w_lcg  = prng_q * C_MULT + C_INC;
        w_lfsr = (prng_q >> 1) ^ (prng_q[0] ? C_TAPS : '0);
        w_next = mode_q ? w_lfsr : w_lcg;

        // Smear the MSB of (bound-1) downward; bound=0 wraps to all ones.
        w_mask = bound_q - OUT_W'(1);
        for (int i = 1; i < OUT_W; i++) begin
            w_mask = w_mask | (w_mask >> i);
        end

        w_cand     = w_next[WIDTH-1 -: OUT_W] & w_mask;
        w_accept   = (bound_q == '0) || (w_cand < bound_q);
        w_step     = (fsm_q == GEN) || (valid_q && ready);
        w_seed_ext = WIDTH'(seed);
    end

    always_comb begin
        fsm_d   = fsm_q;
        prng_d  = prng_q;
        mode_d  = mode_q;
        bound_d = bound_q;
        rand_d  = rand_q;
        valid_d = valid_q;
        rej_d   = rej_q;

        if (seed_load) begin
            // A zero LFSR state is a fixed point, so substitute the default.
            prng_d  = (mode && (w_seed_ext == '0)) ? C_DSEED : w_seed_ext;
            mode_d  = mode;
            bound_d = bound;
            valid_d = 1'b0;
            rej_d   = '0;
            fsm_d   = GEN;
        end else if (w_step) begin
            prng_d = w_next;
            if (w_accept) begin
                rand_d  = w_cand;
                valid_d = 1'b1;
                fsm_d   = VALID;
            end else begin
                valid_d = 1'b0;
                rej_d   = (rej_q == 8'hFF) ? rej_q : rej_q + 8'd1;
                fsm_d   = GEN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= GEN;
            prng_q  <= C_DSEED;
            mode_q  <= 1'b0;
            bound_q <= '0;
            rand_q  <= '0;
            valid_q <= 1'b0;
            rej_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            prng_q  <= prng_d;
            mode_q  <= mode_d;
            bound_q <= bound_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
            rej_q   <= rej_d;
        end
    end

    assign o_rand    = rand_q;
    assign o_valid   = valid_q;
    assign o_rej_cnt = rej_q;

endmodule

`default_nettype wire

// File: tb/tb_prng_stream.sv
//------------------------------------------------------------------------------
// Module   : tb_prng_stream
// Brief    : Self-checking bench for prng_stream against an arithmetic model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prng_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seed;
    logic        seed_load;
    logic        mode;
    logic [15:0] bound;
    logic        ready;
    wire  [15:0] o_rand;
    wire         o_valid;
    wire  [7:0]  o_rej_cnt;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    // Reference model: sample stream derived from the stepping rules.
    longint unsigned m_s;
    bit              m_md;
    int unsigned     m_bd;
    int unsigned     m_r;
    bit              m_v;
    int unsigned     m_rc;

    prng_stream dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .seed_load (seed_load),
        .mode      (mode),
        .bound     (bound),
        .ready     (ready),
        .o_rand    (o_rand),
        .o_valid   (o_valid),
        .o_rej_cnt (o_rej_cnt)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned f_next(longint unsigned s, bit md);
        if (!md) return (s * 64'd1664525 + 64'd1013904223) % 64'h1_0000_0000;
        return (s / 2) ^ (((s % 2) == 1) ? 64'h8020_0003 : 64'd0);
    endfunction

    function automatic int unsigned f_mask(int unsigned bd);
        int unsigned m = 0;
        if (bd == 0) return 32'hFFFF;
        while (m < bd - 1) m = m * 2 + 1;
        return m;
    endfunction

    task automatic m_reset();
        m_s = 1; m_md = 0; m_bd = 0; m_r = 0; m_v = 0; m_rc = 0;
    endtask

    task automatic m_update();
        longint unsigned n;
        int unsigned     c;
        if (rst) begin
            m_reset();
        end else if (seed_load) begin
            m_s  = (mode && seed == 0) ? 1 : seed;
            m_md = mode;
            m_bd = bound;
            m_v  = 0;
            m_rc = 0;
        end else if (!m_v || ready) begin
            n   = f_next(m_s, m_md);
            m_s = n;
            c   = int'(n / 65536) & f_mask(m_bd);
            if (m_bd == 0 || c < m_bd) begin
                m_r = c;
                m_v = 1;
            end else begin
                m_v = 0;
                if (m_rc < 255) m_rc++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m_update();
        #1;
        chk("rand",  32'(o_rand),    m_r);
        chk("valid", 32'(o_valid),   32'(m_v));
        chk("rej",   32'(o_rej_cnt), m_rc);
    endtask

    task automatic load(input logic [15:0] s, input logic md, input logic [15:0] bd, input logic rd);
        seed = s; mode = md; bound = bd; ready = rd; seed_load = 1'b1;
        cyc();
        seed_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; seed = '0; seed_load = 1'b0; mode = 1'b0; bound = '0; ready = 1'b0;
        m_reset();
        #12;
        chk("rst_rand",  32'(o_rand),    32'd0);
        chk("rst_valid", 32'(o_valid),   32'd0);
        chk("rst_rej",   32'(o_rej_cnt), 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        repeat (4) cyc();

        // LCG unbounded from seed 0
        load(16'd0, 1'b0, 16'd0, 1'b1);
        cyc(); chk("lcg0", 32'(o_rand), 32'h3C6E); chk("lcg0_v", 32'(o_valid), 32'd1);
        cyc(); chk("lcg1", 32'(o_rand), 32'h4750); chk("lcg1_v", 32'(o_valid), 32'd1);
        cyc(); chk("lcg2", 32'(o_rand), 32'hD1CC); chk("lcg2_v", 32'(o_valid), 32'd1);

        // Bounded rejection
        load(16'd0, 1'b0, 16'd10, 1'b1);
        cyc(); chk("bnd_c1_v", 32'(o_valid), 32'd0); chk("bnd_c1_rej", 32'(o_rej_cnt), 32'd1);
        cyc(); chk("bnd_c2_r", 32'(o_rand), 32'd0); chk("bnd_c2_v", 32'(o_valid), 32'd1);
        cyc(); chk("bnd_c3_v", 32'(o_valid), 32'd0); chk("bnd_c3_rej", 32'(o_rej_cnt), 32'd2);

        // Backpressure
        load(16'd0, 1'b0, 16'd0, 1'b0);
        cyc();
        repeat (5) begin
            cyc(); chk("bp_hold", 32'(o_rand), 32'h3C6E); chk("bp_v", 32'(o_valid), 32'd1);
        end
        ready = 1'b1;
        cyc(); chk("bp_next", 32'(o_rand), 32'h4750);

        // LFSR zero-seed guard
        load(16'd0, 1'b1, 16'd0, 1'b1);
        cyc(); chk("lfsr0", 32'(o_rand), 32'h8020);
        for (int i = 0; i < 300; i++) begin
            ready = 1'($urandom_range(0, 1));
            cyc();
        end

        // seed_load wins over a same-cycle handshake
        ready = 1'b0;
        cyc(); chk("pri_pre_v", 32'(o_valid), 32'd1);
        load(16'd0, 1'b0, 16'd0, 1'b1);
        chk("pri_v", 32'(o_valid), 32'd0);
        cyc(); chk("pri_first", 32'(o_rand), 32'h3C6E);

        // Asynchronous reset between edges
        repeat (3) cyc();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst_rand",  32'(o_rand),    32'd0);
        chk("arst_valid", 32'(o_valid),   32'd0);
        chk("arst_rej",   32'(o_rej_cnt), 32'd0);
        cyc();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc();

        // bound = 1
        load(16'($urandom), 1'b0, 16'd1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            ready = 1'($urandom_range(0, 1));
            cyc();
            chk("b1_rand", 32'(o_rand), 32'd0);
            chk("b1_rej",  32'(o_rej_cnt), 32'd0);
        end

        // bound = 0xFFFF never yields 0xFFFF
        load(16'($urandom), 1'b0, 16'hFFFF, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            cyc();
            chk("bmax_nofull", 32'(o_rand != 16'hFFFF), 32'd1);
        end

        // Rejection counter saturation over a long run
        load(16'($urandom), 1'b0, 16'h8001, 1'b1);
        repeat (10000) cyc();
        chk("rej_sat", 32'(o_rej_cnt), 32'd255);
        repeat (20) cyc();
        chk("rej_sat_hold", 32'(o_rej_cnt), 32'd255);

        // Randomized loads; mode/bound wiggle without seed_load
        for (int k = 0; k < 20; k++) begin
            load(16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), 1'($urandom));
            for (int i = 0; i < 200; i++) begin
                ready = 1'($urandom_range(0, 3) != 0);
                mode  = 1'($urandom);
                bound = 16'($urandom);
                seed  = 16'($urandom);
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
